amax10_qsys_ledr_pwm: RTL and testbench

- Downstream stage of the LEDR PIO. Consumes the 8-bit LED pattern the PIO drives on its output port and produces the physical LED pins.
- Adds global PWM brightness and per-LED blink.
- Configured by the Nios II over its own Avalon-MM slave, which is a separate register window from the PIO.
- Sits between the PIO export and the top-level LEDR pins.

---
 rtl/amax10_qsys_ledr_pwm.sv | 143 ++++++++++++++
 tb/tb_amax10_qsys_ledr_pwm.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/amax10_qsys_ledr_pwm.sv
// LEDR PWM/blink stage between the LEDR PIO export and the board LED pins.
// Adds a global PWM brightness and a per-LED blink, both configured through
// a small Avalon-MM slave. Brightness and pattern are shadowed at the PWM
// period boundary, so a partial period is never driven onto the pins.
module amax10_qsys_ledr_pwm #(
  parameter int CLK_DIV = 16,  // clocks per PWM tick, 1..65535
  parameter int BLINK_W = 24   // blink half-period width, 1..32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  led_pattern,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led_out
);

  localparam logic [15:0]        PRE_MAX = 16'(CLK_DIV - 1);
  localparam logic [7:0]         PWM_MAX = 8'd254;  // 255-tick period
  localparam logic [BLINK_W-1:0] HP_ONE  = {{(BLINK_W-1){1'b0}}, 1'b1};
  localparam logic [BLINK_W-1:0] HP_ZERO = '0;

  // Software-visible registers
  logic [7:0]         duty_reg;
  logic [7:0]         blink_mask_reg;
  logic [BLINK_W-1:0] half_period_reg;

  // Timing and shadow state
  logic [15:0]        pre_cnt_reg;
  logic [7:0]         pwm_cnt_reg;
  logic [7:0]         act_duty_reg;
  logic [7:0]         act_pat_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_phase_reg;
  logic [7:0]         led_out_reg;
  logic [7:0]         led_next;

  logic wr_en;
  logic hp_wr;
  logic tick;
  logic boundary;
  logic pwm_on;

  assign wr_en    = chipselect & ~write_n;
  assign hp_wr    = wr_en & (address == 2'd2);
  assign tick     = (pre_cnt_reg == PRE_MAX);
  assign boundary = tick & (pwm_cnt_reg == PWM_MAX);
  assign pwm_on   = (pwm_cnt_reg < act_duty_reg);

  // Upper write-data bits beyond the half-period width are not stored
  generate
    if (BLINK_W < 32) begin : g_unused_wd
      logic unused_wd;
      assign unused_wd = ^writedata[31:BLINK_W];
    end
  endgenerate

  // Register file writes; address 3 (STATUS) is read-only
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      duty_reg        <= 8'hFF;
      blink_mask_reg  <= 8'h00;
      half_period_reg <= HP_ZERO;
    end else if (wr_en) begin
      case (address)
        2'd0:    duty_reg        <= writedata[7:0];
        2'd1:    blink_mask_reg  <= writedata[7:0];
        2'd2:    half_period_reg <= writedata[BLINK_W-1:0];
        default: ;
      endcase
    end
  end

  // Prescaler: one PWM tick every CLK_DIV clocks
  always_ff @(posedge clk) begin
    if (!reset_n)  pre_cnt_reg <= 16'd0;
    else if (tick) pre_cnt_reg <= 16'd0;
    else           pre_cnt_reg <= pre_cnt_reg + 16'd1;
  end

  // PWM counter over 0..254
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_cnt_reg <= 8'd0;
    end else if (tick) begin
      pwm_cnt_reg <= (pwm_cnt_reg == PWM_MAX) ? 8'd0 : pwm_cnt_reg + 8'd1;
    end
  end

  // Shadow load at the period boundary; a same-edge DUTY write is seen next period
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      act_duty_reg <= 8'hFF;
      act_pat_reg  <= 8'h00;
    end else if (boundary) begin
      act_duty_reg <= duty_reg;
      act_pat_reg  <= led_pattern;
    end
  end

  // Blink half-period counter; a zero half-period parks the phase at "on"
  always_ff @(posedge clk) begin
    if (!reset_n || hp_wr || (half_period_reg == HP_ZERO)) begin
      blink_cnt_reg   <= HP_ZERO;
      blink_phase_reg <= 1'b1;
    end else if (blink_cnt_reg == half_period_reg - HP_ONE) begin
      blink_cnt_reg   <= HP_ZERO;
      blink_phase_reg <= ~blink_phase_reg;
    end else begin
      blink_cnt_reg   <= blink_cnt_reg + HP_ONE;
    end
  end

  // Per-LED drive term; the blink mask is applied live
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_led
      assign led_next[gi] = act_pat_reg[gi] & pwm_on &
                            ~(blink_mask_reg[gi] & ~blink_phase_reg);
    end
  endgenerate

  // Registered LED pins
  always_ff @(posedge clk) begin
    if (!reset_n) led_out_reg <= 8'h00;
    else          led_out_reg <= led_next;
  end

  assign led_out = led_out_reg;

  // Zero-wait-state read mux
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {24'd0, duty_reg};
      2'd1:    readdata = {24'd0, blink_mask_reg};
      2'd2:    readdata = 32'(half_period_reg);
      default: readdata = {23'd0, blink_phase_reg, pwm_cnt_reg};
    endcase
  end

endmodule

// File: tb/tb_amax10_qsys_ledr_pwm.sv
// Bench for amax10_qsys_ledr_pwm: two instances (CLK_DIV=1 and 16) share
// stimulus; an arithmetic model derives LED and register values from cycle
// counts since reset and since the last half-period write.
module tb_amax10_qsys_ledr_pwm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  led_pattern = 8'h00;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] rd0, rd1;
  logic [7:0]  led0, led1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  amax10_qsys_ledr_pwm #(.CLK_DIV(1), .BLINK_W(24)) u_dut (
    .clk(clk), .reset_n(reset_n), .led_pattern(led_pattern), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(rd0), .led_out(led0));

  amax10_qsys_ledr_pwm #(.CLK_DIV(16), .BLINK_W(24)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .led_pattern(led_pattern), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(rd1), .led_out(led1));

  // ---------------- behavioural model ----------------
  int unsigned divs [2] = '{1, 16};
  int unsigned m_n [2];           // clock edges since reset release
  logic [7:0]  m_act_duty [2];
  logic [7:0]  m_act_pat [2];
  logic [7:0]  m_led [2];
  logic [7:0]  m_duty, m_mask;
  logic [23:0] m_hp;
  int unsigned m_e;               // edges since reset or last half-period write
  bit          m_valid = 0;

  function automatic bit phase_of(int unsigned e, logic [23:0] hp);
    if (hp == 24'd0) return 1'b1;
    return ((e / 32'(hp)) % 2) == 0;
  endfunction

  function automatic logic [7:0] pc_of(int i);
    return 8'((m_n[i] / divs[i]) % 255);
  endfunction

  function automatic logic [31:0] exp_rd(int i, logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, m_duty};
      2'd1:    return {24'd0, m_mask};
      2'd2:    return {8'd0, m_hp};
      default: return {23'd0, phase_of(m_e, m_hp), pc_of(i)};
    endcase
  endfunction

  always @(posedge clk) begin
    bit ph;
    bit on;
    int unsigned k;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_n[i] = 0; m_act_duty[i] = 8'hFF; m_act_pat[i] = 8'h00; m_led[i] = 8'h00;
      end
      m_duty = 8'hFF; m_mask = 8'h00; m_hp = 24'd0; m_e = 0;
      m_valid = 1;
    end else if (m_valid) begin
      ph = phase_of(m_e, m_hp);
      for (int i = 0; i < 2; i++) begin
        on = (pc_of(i) < m_act_duty[i]);
        m_led[i] = on ? (m_act_pat[i] & ~(m_mask & ~{8{ph}})) : 8'h00;
        k = m_n[i] + 1;
        if ((k % divs[i]) == 0 && ((k / divs[i]) % 255) == 0) begin
          m_act_duty[i] = m_duty;
          m_act_pat[i]  = led_pattern;
        end
        m_n[i] = k;
      end
      m_e = m_e + 1;
      if (chipselect && !write_n) begin
        case (address)
          2'd0: m_duty = writedata[7:0];
          2'd1: m_mask = writedata[7:0];
          2'd2: begin m_hp = writedata[23:0]; m_e = 0; end
          default: ;
        endcase
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid && reset_n) begin
      check("led_div1", {24'd0, led0}, {24'd0, m_led[0]});
      check("led_div16", {24'd0, led1}, {24'd0, m_led[1]});
      check("rd_div1", rd0, exp_rd(0, address));
      check("rd_div16", rd1, exp_rd(1, address));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(string name, int i, logic [1:0] a, logic [31:0] exp);
    address = a; #1;
    check(name, (i == 0) ? rd0 : rd1, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_on, cnt_off, t1, t2, t;
    logic [7:0] v, v2;
    int unsigned r;

    // Reset defaults
    led_pattern = 8'hA5;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (255) step();
    check("rst_led_before_boundary", {24'd0, led0}, 32'h0);
    step();
    check("rst_led_after_boundary", {24'd0, led0}, 32'hA5);
    rd_chk("rst_rd_duty", 0, 2'd0, 32'hFF);
    rd_chk("rst_rd_mask", 0, 2'd1, 32'h0);
    rd_chk("rst_rd_hp", 0, 2'd2, 32'h0);
    repeat (10) begin
      step();
      check("rst_led_steady", {24'd0, led0}, 32'hA5);
    end

    // Randomized traffic
    for (int n = 0; n < 5000; n++) begin
      if ($urandom_range(0, 63) == 0) led_pattern = 8'($urandom);
      r = $urandom_range(0, 47);
      address = 2'($urandom);
      writedata = $urandom;
      if (address == 2'd2) writedata[23:0] = 24'($urandom_range(0, 20));
      if (address == 2'd0 && $urandom_range(0, 3) == 0)
        writedata[7:0] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      chipselect = 1'b0; write_n = 1'b1;
      if (r == 0) begin chipselect = 1'b1; write_n = 1'b0; end
      else if (r == 1) begin chipselect = 1'b0; write_n = 1'b0; end
      else if (r == 2) begin chipselect = 1'b1; write_n = 1'b1; end
      step();
    end
    chipselect = 1'b0; write_n = 1'b1;

    // Duty 25%
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h0);
    wr(2'd0, 32'd64);
    led_pattern = 8'hFF;
    repeat (510) step();
    cnt_on = 0; cnt_off = 0;
    repeat (255) begin
      step();
      if (led0 == 8'hFF) cnt_on++;
      else if (led0 == 8'h00) cnt_off++;
    end
    check("duty25_on_clocks", cnt_on, 32'd64);
    check("duty25_off_clocks", cnt_off, 32'd191);

    // Duty 0
    wr(2'd0, 32'd0);
    repeat (510) step();
    cnt_on = 0;
    repeat (255) begin
      step();
      if (led0 != 8'h00) cnt_on++;
    end
    check("duty0_lit_clocks", cnt_on, 32'd0);

    // Blink
    wr(2'd0, 32'd255);
    wr(2'd1, 32'h01);
    repeat (300) step();
    wr(2'd2, 32'd10);
    for (int i = 0; i < 20; i++) begin
      step();
      check("blink_seq", {24'd0, led0}, (i < 10) ? 32'hFF : 32'hFE);
    end
    wr(2'd2, 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("blink_off_steady", {24'd0, led0}, 32'hFF);
    end

    // Prescale: pwm_cnt on the CLK_DIV=16 instance advances every 16 clocks
    address = 2'd3; #1;
    v = rd1[7:0];
    t1 = -1; t2 = -1;
    for (t = 0; t < 40 && t2 < 0; t++) begin
      step();
      v2 = rd1[7:0];
      if (v2 != v) begin
        if (t1 < 0) begin
          t1 = t;
          check("prescale_incr", {24'd0, v2}, (v == 8'd254) ? 32'd0 : 32'(v) + 32'd1);
        end else begin
          t2 = t;
        end
        v = v2;
      end
    end
    check("prescale_interval", t2 - t1, 32'd16);

    // STATUS is read-only
    wr(2'd3, 32'hFFFF_FFFF);
    rd_chk("ro_duty", 0, 2'd0, 32'hFF);
    rd_chk("ro_mask", 0, 2'd1, 32'h01);
    rd_chk("ro_hp", 0, 2'd2, 32'h0);

    // Reset mid-operation with blink active
    wr(2'd2, 32'd10);
    t = 0;
    while (pc_of(0) != 8'd130 && t < 300) begin step(); t++; end
    check("midrst_reach_130", {24'd0, pc_of(0)}, 32'd130);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midrst_led", {24'd0, led0}, 32'h0);
    rd_chk("midrst_status", 0, 2'd3, 32'h100);
    rd_chk("midrst_duty", 0, 2'd0, 32'hFF);
    rd_chk("midrst_mask", 0, 2'd1, 32'h0);
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
